rom_burst_reader: RTL and testbench
===================================

// Module: rom_burst_reader
// PURPOSE
//  Bus-master counterpart of the 8-bit-address/8-bit-data ROM: on a start command it
//  drives en/rwb/addr over a contiguous address range, captures the combinational read
//  data and streams each byte out on a valid/ready channel. It sits between a ROM
//  instance and any consumer (UART TX, table-lookup engine, test harness).
// PARAMETERS
//  AW  8  address width; ROM depth 2**AW, addresses wrap modulo 2**AW
//  DW  8  data width
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     synchronous, active-low reset
//  start      in   1     command strobe; sampled only in IDLE
//  base       in   AW    first address of burst, latched on accepted start
//  len        in   AW+1  byte count 0..2**AW, latched on accepted start
//  busy       out  1     high from the cycle after an accepted start until done
//  done       out  1     one-cycle pulse after the last beat is accepted (or len==0)
//  en         out  1     ROM enable, high only in FETCH
//  rwb        out  1     read/write-bar to ROM; constant 1 (read)
//  addr       out  AW    ROM address, registered
//  data       in   DW    ROM read data, combinational from addr
//  out_valid  out  1     stream valid
//  out_ready  in   1     stream ready from consumer
//  out_data   out  DW    stream byte, registered
//  out_last   out  1     qualifies final beat of burst
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE; busy,done,en,out_valid,out_last=0; addr,out_data=0;
//   rwb=1. Reset mid-burst aborts immediately; no partial done, out_valid drops next edge.
//  FSM IDLE -> FETCH -> SEND -> (FETCH | DONE) -> IDLE:
//   IDLE : start&&len!=0 -> addr<=base, rem<=len, en<=1, busy<=1, go FETCH.
//          start&&len==0 -> busy<=1, go DONE (no beats issued).
//   FETCH: out_data<=data, out_valid<=1, out_last<=(rem==1), en<=0, go SEND.
//   SEND : hold out_data/out_valid/out_last stable while !out_ready.
//          On out_valid&&out_ready: out_valid<=0; if out_last go DONE,
//          else addr<=addr+1 (mod 2**AW), rem<=rem-1, en<=1, go FETCH.
//   DONE : done<=1 for exactly one cycle, busy<=0 same edge, go IDLE.
//  Latency: start -> first out_valid = 2 cycles; max throughput 1 byte / 2 cycles.
//  start while busy is ignored; base/len changes after accept have no effect.
//  len==2**AW reads every location exactly once, wrapping through address 0.
//  rem is AW+1 bits; never underflows (last beat detected at rem==1).
// CONFIGURATION
//  ROM_BURST_READER_CHECKSUM_EN defined: extra port checksum out DW = mod-2**DW sum of all
//   bytes accepted on the stream in the current burst; cleared to 0 on accepted start
//   and reset, valid and stable from the done pulse until next accepted start.
//  Not defined: port and accumulator absent; all other behaviour identical.
// STRUCTURE
//  Shared package rom_pkg: AW/DW defaults, state enum {IDLE,FETCH,SEND,DONE},
//   ROM_RWB_READ=1'b1 constant (shared with the ROM and future RAM writer).
//  Single flat module; no sub-module (FSM + counters too small to split).
// TESTING  (ROM loaded with standard table: data=addr except 24->16, 56->48, ..., 248->240)
//  base=22 len=4, ready=1 -> beats 22,23,16,25; out_last only on 25; done 1 cycle later.
//  base=254 len=4 -> addr 254,255,0,1; beats 254,255,0,1; no glitch on wrap.
//  base=5 len=3, out_ready=0 for 5 cycles on beat 1 -> out_data=6 held, addr stays 6.
//  len=0 start -> busy 1 cycle, done pulse, out_valid never asserted, en never high.
//  base=0 len=256, rst=0 asserted during 10th beat -> all outputs reset next edge, no done;
//   new start base=0 len=1 -> single beat 0 with out_last.
//  CHECKSUM_EN: base=0 len=4 -> checksum=6 at done; base=248 len=2 -> 240+249=489 mod 256=233.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared definitions for the 8-bit ROM, its burst reader and future RAM writer.
package rom_pkg;

   localparam int AW_DEFAULT = 8;
   localparam int DW_DEFAULT = 8;

   localparam logic ROM_RWB_READ = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rom_burst_reader_if.sv
// Command, ROM-bus and byte-stream signals of rom_burst_reader; optional checksum
// port appears when ROM_BURST_READER_CHECKSUM_EN is defined.
interface rom_burst_reader_if
   import rom_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) ();

   // Stream handshake: a beat transfers on every rising edge where out_valid and
   // out_ready are both high; once raised, out_valid/out_data/out_last hold until then.
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic          en;
   logic          rwb;
   logic [AW-1:0] addr;
   logic [DW-1:0] data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   state_t        dbg_state;
`ifdef ROM_BURST_READER_CHECKSUM_EN
   logic [DW-1:0] checksum;

   modport master (
      input  start, base, len, data, out_ready,
      output busy, done, en, rwb, addr, out_valid, out_data, out_last, dbg_state,
      output checksum
   );

   modport slave (
      output start, base, len, data, out_ready,
      input  busy, done, en, rwb, addr, out_valid, out_data, out_last, dbg_state,
      input  checksum
   );
`else
   modport master (
      input  start, base, len, data, out_ready,
      output busy, done, en, rwb, addr, out_valid, out_data, out_last, dbg_state
   );

   modport slave (
      output start, base, len, data, out_ready,
      input  busy, done, en, rwb, addr, out_valid, out_data, out_last, dbg_state
   );
`endif

endinterface

// File: rtl/rom_burst_reader.sv
// Reads a contiguous (wrapping) ROM address range and streams each byte out on a
// valid/ready channel. ROM_BURST_READER_CHECKSUM_EN adds a running byte checksum.
module rom_burst_reader
   import rom_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   rom_burst_reader_if.master     bus
);

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [AW:0]   r_rem, w_rem_nxt;
   logic          r_en, w_en_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic          r_out_valid, w_out_valid_nxt;
   logic [DW-1:0] r_out_data, w_out_data_nxt;
   logic          r_out_last, w_out_last_nxt;
`ifdef ROM_BURST_READER_CHECKSUM_EN
   logic [DW-1:0] r_checksum, w_checksum_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_rem       <= '0;
         r_en        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
`ifdef ROM_BURST_READER_CHECKSUM_EN
         r_checksum  <= '0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_rem       <= w_rem_nxt;
         r_en        <= w_en_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_last  <= w_out_last_nxt;
`ifdef ROM_BURST_READER_CHECKSUM_EN
         r_checksum  <= w_checksum_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_rem_nxt       = r_rem;
      w_en_nxt        = r_en;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_out_last_nxt  = r_out_last;
`ifdef ROM_BURST_READER_CHECKSUM_EN
      w_checksum_nxt  = r_checksum;
`endif
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_busy_nxt = 1'b1;
`ifdef ROM_BURST_READER_CHECKSUM_EN
               w_checksum_nxt = '0;
`endif
               if (bus.len != '0) begin
                  w_addr_nxt  = bus.base;
                  w_rem_nxt   = bus.len;
                  w_en_nxt    = 1'b1;
                  w_state_nxt = FETCH;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         FETCH: begin
            w_out_data_nxt  = bus.data;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = (r_rem == (AW+1)'(1));
            w_en_nxt        = 1'b0;
            w_state_nxt     = SEND;
         end
         SEND: begin
            if (r_out_valid && bus.out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_out_last_nxt  = 1'b0;
`ifdef ROM_BURST_READER_CHECKSUM_EN
               w_checksum_nxt  = r_checksum + r_out_data;
`endif
               if (r_out_last) begin
                  w_state_nxt = DONE;
               end else begin
                  // Address wraps naturally at 2**AW; rem stops at 1, never reaching 0 here.
                  w_addr_nxt  = r_addr + AW'(1);
                  w_rem_nxt   = r_rem - (AW+1)'(1);
                  w_en_nxt    = 1'b1;
                  w_state_nxt = FETCH;
               end
            end
         end
         DONE: begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.en        = r_en;
   assign bus.rwb       = ROM_RWB_READ;
   assign bus.addr      = r_addr;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.dbg_state = r_state;
`ifdef ROM_BURST_READER_CHECKSUM_EN
   assign bus.checksum  = r_checksum;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: table of bursts plus random bursts against a queue model
// of the standard ROM table; checksum checked when ROM_BURST_READER_CHECKSUM_EN is defined.
module tb_rom_burst_reader;
   import rom_pkg::*;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rom_burst_reader_if bus ();

   rom_burst_reader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Standard table: data=addr except 24,56,...,248 which read 8 lower.
   function automatic logic [7:0] rom_f(input logic [7:0] a);
      return (a[4:0] == 5'd24) ? a - 8'd8 : a;
   endfunction

   assign bus.data = rom_f(bus.addr);

   typedef struct {
      logic [7:0] base;
      logic [8:0] len;
      int         pct;
      int         hold_beat;
      int         hold_cyc;
      logic [7:0] exp_first;
      logic [7:0] exp_final;
   } vec_t;

   vec_t       vecs[8];
   logic [7:0] exp_q[$];
   logic [7:0] first_b;
   logic [7:0] last_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_burst(input logic [7:0] b, input logic [8:0] l, input int pct,
                            input int hold_beat, input int hold_cyc);
      int         got;
      int         cyc;
      int         held;
      int         budget;
      bit         seen_done;
      bit         stalled;
      bit         rdy;
      logic [7:0] prev_data;
      logic [7:0] ea;
`ifdef ROM_BURST_READER_CHECKSUM_EN
      logic [7:0] sum;
      sum = 8'd0;
`endif
      exp_q.delete();
      for (int i = 0; i < int'(l); i++) begin
         exp_q.push_back(rom_f(b + 8'(i)));
`ifdef ROM_BURST_READER_CHECKSUM_EN
         sum = sum + rom_f(b + 8'(i));
`endif
      end
      got = 0; cyc = 0; held = 0; seen_done = 0; stalled = 0; prev_data = '0;
      budget = 40 * int'(l) + 50;
      @(negedge clk);
      bus.start = 1'b1; bus.base = b; bus.len = l; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0; bus.base = 8'($urandom); bus.len = 9'($urandom);
      while (!seen_done && cyc < budget) begin
         ea = b + 8'(got);
         check("rwb_read", 32'(bus.rwb), 32'd1);
         if (cyc == 0) check("busy_after_start", 32'(bus.busy), 32'd1);
         if (cyc == 1) check("first_valid_latency", 32'(bus.out_valid), 32'(l != 9'd0));
         if (bus.en) begin
            check("en_only_nonzero_len", 32'(l != 9'd0), 32'd1);
            check("fetch_addr", 32'(bus.addr), 32'(ea));
         end
         if (stalled) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'(prev_data));
            check("hold_addr", 32'(bus.addr), 32'(ea));
         end
         if (bus.done) begin
            seen_done = 1;
            check("busy_low_at_done", 32'(bus.busy), 32'd0);
            check("beat_count", 32'(got), 32'(l));
`ifdef ROM_BURST_READER_CHECKSUM_EN
            check("checksum", 32'(bus.checksum), 32'(sum));
`endif
         end else begin
            if (bus.out_valid && got == hold_beat && held < hold_cyc) begin
               rdy = 1'b0;
               held++;
            end else begin
               rdy = ($urandom_range(1, 100) <= pct);
            end
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
               if (exp_q.size() == 0) begin
                  check("extra_beat", 32'(got), 32'(l));
               end else begin
                  check("beat_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
               end
               check("beat_last", 32'(bus.out_last), 32'(got == int'(l) - 1));
               if (got == 0) first_b = bus.out_data;
               last_b = bus.out_data;
               got++;
               stalled = 0;
            end else begin
               stalled = bus.out_valid;
               prev_data = bus.out_data;
            end
            bus.start = bus.busy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      if (!seen_done) check("done_timeout", 32'(cyc), 32'(budget + 1));
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_midburst();
      int beats;
      beats = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.base = 8'd0; bus.len = 9'd256; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 100 && beats < 10; c++) begin
         if (bus.out_valid) beats++;
         if (beats == 10) rst = 1'b0;
         else @(negedge clk);
      end
      check("reset_reached_beat10", 32'(beats), 32'd10);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_en", 32'(bus.en), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_last", 32'(bus.out_last), 32'd0);
      check("rst_addr", 32'(bus.addr), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
      rst = 1'b1;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post_rst_no_done", 32'(bus.done), 32'd0);
         check("post_rst_idle", 32'(bus.busy | bus.out_valid | bus.en), 32'd0);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      vecs[0] = '{8'd22,  9'd4,   100, -1, 0, 8'd22,  8'd25};
      vecs[1] = '{8'd254, 9'd4,   100, -1, 0, 8'd254, 8'd1};
      vecs[2] = '{8'd5,   9'd3,   100,  1, 5, 8'd5,   8'd7};
      vecs[3] = '{8'd9,   9'd0,   100, -1, 0, 8'd0,   8'd0};
      vecs[4] = '{8'd248, 9'd2,   100, -1, 0, 8'd240, 8'd249};
      vecs[5] = '{8'd0,   9'd4,   60,  -1, 0, 8'd0,   8'd3};
      vecs[6] = '{8'd0,   9'd256, 100, -1, 0, 8'd0,   8'd255};
      vecs[7] = '{8'd100, 9'd1,   50,   0, 3, 8'd100, 8'd100};

      rst = 1'b0;
      bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_outputs", 32'({bus.done, bus.en, bus.out_valid, bus.out_last}), 32'd0);
      check("reset_addr_data", 32'({bus.addr, bus.out_data}), 32'd0);
      check("reset_rwb", 32'(bus.rwb), 32'd1);
      check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
      rst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         first_b = '0;
         last_b = '0;
         run_burst(vecs[v].base, vecs[v].len, vecs[v].pct, vecs[v].hold_beat, vecs[v].hold_cyc);
         if (vecs[v].len != 9'd0) begin
            check("vec_first_beat", 32'(first_b), 32'(vecs[v].exp_first));
            check("vec_last_beat", 32'(last_b), 32'(vecs[v].exp_final));
         end
      end

      reset_midburst();
      first_b = 8'hff;
      run_burst(8'd0, 9'd1, 100, -1, 0);
      check("after_reset_single_beat", 32'(first_b), 32'd0);

      for (int r = 0; r < 20; r++) begin
         run_burst(8'($urandom), 9'($urandom_range(0, 40)), $urandom_range(30, 100),
                   $urandom_range(0, 3), $urandom_range(0, 4));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      n_fail++;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
